// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and baud-rate helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

    // Width of a counter that must hold 0..clks-1.
    function automatic int unsigned cnt_width(input int unsigned clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_drain_if.sv
// Passive FIFO read port: head visible while not empty, rd_en pops one entry.
interface uart_tx_drain_if #(
    parameter int unsigned WIDTH = 8
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_rd_en;

    modport master (input fifo_empty, input fifo_data, output fifo_rd_en);
    modport slave  (output fifo_empty, output fifo_data, input fifo_rd_en);
endinterface

// File: rtl/uart_baud_tick.sv
// Clearable modulo-CLKS_PER_BIT counter; bit_end_o marks the last cycle of a bit.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic bit_end_o
);
    localparam int unsigned   CW   = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count_q, count_d;

    assign bit_end_o = (count_q == LAST);

    always_comb begin
        count_d = count_q + 1'b1;
        if (clear_i || bit_end_o) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/uart_tx_drain.sv
// Drains the TX byte FIFO and serializes each byte as a UART frame on tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_drain
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 115200,
    parameter int unsigned WIDTH    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_tx_drain_if.master        fifo,
    output logic                   tx,
    output logic                   busy,
    output logic                   tx_done
);
    localparam int unsigned   C        = clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned   IW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    tx_state_e        state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             tx_q, tx_d;
    logic             rd_q, rd_d;
    logic             done_q, done_d;
    logic             bit_end;

    uart_baud_tick #(
        .CLKS_PER_BIT(C)
    ) u_tick (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (state_q == IDLE),
        .bit_end_o (bit_end)
    );

    // tx is registered, so each transition loads the level of the bit that follows.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        rd_d    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo.fifo_empty) begin
                    shift_d = fifo.fifo_data;
                    rd_d    = 1'b1;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = ^shift_q;
                        state_d = PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                        tx_d  = shift_q[idx_d];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            rd_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            rd_q    <= rd_d;
            done_q  <= done_d;
        end
    end

    assign fifo.fifo_rd_en = rd_q;
    assign tx              = tx_q;
    assign tx_done         = done_q;
    assign busy            = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: frame-level model plus directed literal checks, C=8.
module tb_uart_tx_drain;
    localparam int unsigned CLK_FREQ = 8;
    localparam int unsigned BAUD     = 1;
    localparam int unsigned WIDTH    = 8;
    localparam int unsigned C        = 8;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned PAR = 1;
`else
    localparam int unsigned PAR = 0;
`endif
    localparam int unsigned FRAME    = (WIDTH + 2 + PAR) * C;
    localparam int          DONE_CYC = FRAME + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx, busy, tx_done;

    uart_tx_drain_if #(.WIDTH(WIDTH)) fifo_if ();

    uart_tx_drain #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .WIDTH    (WIDTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .fifo    (fifo_if),
        .tx      (tx),
        .busy    (busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int cur = 0;
    logic rd_seen = 1'b0;
    logic [7:0] fq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fifo_update();
        fifo_if.fifo_empty = (fq.size() == 0);
        fifo_if.fifo_data  = (fq.size() != 0) ? fq[0] : 8'h00;
    endtask

    task automatic fifo_push(input logic [7:0] b);
        fq.push_back(b);
        fifo_update();
    endtask

    // FIFO pop: the head refreshes one cycle after the strobe.
    always @(posedge clk) begin
        #1;
        if (rd_seen === 1'b1) begin
            if (fq.size() != 0) fq.delete(0);
            fifo_update();
        end
    end

    // Expected line level at position k of a frame (k=0: not in a frame).
    function automatic logic exp_tx(input int k, input logic [7:0] b);
        int slot;
        if (k == 0) return 1'b1;
        slot = (k - 1) / C;
        if (slot == 0) return 1'b0;
        if (slot <= WIDTH) return b[slot-1];
        if (PAR == 1 && slot == WIDTH + 1) return ^b;
        return 1'b1;
    endfunction

    int         mk = 0;
    logic       done_exp = 1'b0;
    logic [7:0] mbyte = 8'h00;
    logic       armed = 1'b0;

    always @(negedge clk) begin
        rd_seen = fifo_if.fifo_rd_en;
        if (fifo_if.fifo_rd_en === 1'b1) rd_cnt++;
        if (tx_done === 1'b1) done_cnt++;
        if (armed) begin
            chk("model_tx", tx, exp_tx(mk, mbyte));
            chk("model_busy", busy, mk != 0);
            chk("model_rd_en", fifo_if.fifo_rd_en, mk == 1);
            chk("model_tx_done", tx_done, done_exp);
        end
        if (rst) begin
            mk = 0;
            done_exp = 1'b0;
            armed = 1'b1;
        end else if (mk != 0) begin
            if (mk == FRAME) begin
                mk = 0;
                done_exp = 1'b1;
            end else begin
                mk++;
                done_exp = 1'b0;
            end
        end else begin
            done_exp = 1'b0;
            if (!fifo_if.fifo_empty) begin
                mk = 1;
                mbyte = fifo_if.fifo_data;
            end
        end
    end

    task automatic goto(input int t);
        while (cur < t) begin
            @(negedge clk);
            cur++;
        end
        #1;
    endtask

    task automatic start_byte(input logic [7:0] b);
        @(posedge clk);
        #2;
        fifo_push(b);
        cur = -1;
    endtask

    int unsigned pat_a5[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    int r0, d0;

    initial begin
        fifo_update();
        rst = 1'b1;

        // Reset held with data waiting: nothing leaves until release.
        @(posedge clk);
        #2;
        fifo_push(8'h3C);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("rst_tx", tx, 1);
            chk("rst_busy", busy, 0);
            chk("rst_rd_en", fifo_if.fifo_rd_en, 0);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        cur = -1;
        goto(0);
        chk("rel_busy0", busy, 0);
        goto(1);
        chk("rel_rd_en1", fifo_if.fifo_rd_en, 1);
        chk("rel_start", tx, 0);
        goto(DONE_CYC);
        chk("rel_done", tx_done, 1);
        goto(DONE_CYC + 2);

        // Single byte 0xA5.
        start_byte(8'hA5);
        goto(0);
        chk("a5_busy0", busy, 0);
        chk("a5_rd0", fifo_if.fifo_rd_en, 0);
        goto(1);
        chk("a5_rd1", fifo_if.fifo_rd_en, 1);
        chk("a5_start1", tx, 0);
        chk("a5_busy1", busy, 1);
        goto(2);
        chk("a5_rd2", fifo_if.fifo_rd_en, 0);
        goto(8);
        chk("a5_start8", tx, 0);
        for (int i = 0; i < 8; i++) begin
            goto(9 + 8 * i);
            chk("a5_bit", tx, pat_a5[i]);
        end
        goto(72);
        chk("a5_bit7_end", tx, 1);
        goto(73);
        chk("a5_after_data", tx, (PAR == 1) ? 0 : 1);
        goto(DONE_CYC - 1);
        chk("a5_busy_last", busy, 1);
        chk("a5_nodone", tx_done, 0);
        goto(DONE_CYC);
        chk("a5_done", tx_done, 1);
        chk("a5_idle_busy", busy, 0);
        chk("a5_idle_tx", tx, 1);
        goto(DONE_CYC + 1);
        chk("a5_done_pulse", tx_done, 0);
        goto(DONE_CYC + 3);

        // Back-to-back 0x00 then 0xFF.
        r0 = rd_cnt;
        @(posedge clk);
        #2;
        fifo_push(8'h00);
        fifo_push(8'hFF);
        cur = -1;
        goto(9);
        chk("b2b_zero_bit0", tx, 0);
        goto(DONE_CYC);
        chk("b2b_done1", tx_done, 1);
        goto(DONE_CYC + 1);
        chk("b2b_start2_rd", fifo_if.fifo_rd_en, 1);
        chk("b2b_start2_tx", tx, 0);
        chk("b2b_start2_busy", busy, 1);
        for (int i = 0; i < 8; i++) begin
            goto(DONE_CYC + 1 + C + 8 * i);
            chk("b2b_ff_bit", tx, 1);
        end
        goto(2 * DONE_CYC);
        chk("b2b_done2", tx_done, 1);
        goto(2 * DONE_CYC + 2);
        chk("b2b_rd_pulses", rd_cnt - r0, 2);

        // Reset during data bit 3 of 0x5A.
        r0 = rd_cnt;
        d0 = done_cnt;
        start_byte(8'h5A);
        goto(34);
        chk("mid_bit3", tx, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        goto(36);
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_busy", busy, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        goto(56);
        chk("mid_no_done", done_cnt - d0, 0);
        chk("mid_one_pop", rd_cnt - r0, 1);
        chk("mid_idle_busy", busy, 0);
        chk("mid_fifo_empty", fifo_if.fifo_empty, 1);
        start_byte(8'h81);
        goto(1);
        chk("mid_resume_rd", fifo_if.fifo_rd_en, 1);
        goto(DONE_CYC + 2);

`ifdef UART_TX_PARITY_EN
        start_byte(8'h07);
        goto(73);
        chk("par07_first", tx, 1);
        goto(80);
        chk("par07_last", tx, 1);
        goto(89);
        chk("par07_done", tx_done, 1);
        goto(91);
        start_byte(8'h03);
        goto(73);
        chk("par03_first", tx, 0);
        goto(80);
        chk("par03_last", tx, 0);
        goto(DONE_CYC + 2);
`endif

        // Three bytes written on consecutive cycles drain in order.
        r0 = rd_cnt;
        d0 = done_cnt;
        start_byte(8'h11);
        @(posedge clk);
        #2;
        fifo_push(8'h22);
        @(posedge clk);
        #2;
        fifo_push(8'h33);
        begin
            int n;
            n = 0;
            while (n < 600 && !(fifo_if.fifo_empty && !busy && done_cnt - d0 == 3)) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk("burst_timeout", n < 600, 1);
        end
        repeat (4) @(negedge clk);
        #1;
        chk("burst_pops", rd_cnt - r0, 3);
        chk("burst_dones", done_cnt - d0, 3);
        chk("burst_empty", fifo_if.fifo_empty, 1);
        chk("burst_idle_tx", tx, 1);
        chk("burst_idle_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end
endmodule
